// File: rtl/seq_svm_mac.sv
// seq_svm_mac: multi-lane sequential linear-SVM evaluator (bias preload, LANES MACs per beat, start/done handshake).
// Optional build macro SEQ_SVM_SAT_EN: saturate every accumulator update instead of wrapping.
module seq_svm_mac #(
    parameter int N_FEATURES = 16,
    parameter int IN_W       = 4,
    parameter int W_W        = 8,
    parameter int B_W        = 8,
    parameter int BIAS_SHIFT = 4,
    parameter int LANES      = 1,
    parameter int ACC_W      = W_W + IN_W + $clog2(N_FEATURES) + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [W_W*N_FEATURES-1:0]  weights,
    input  logic [B_W-1:0]             bias,
    input  logic [IN_W*N_FEATURES-1:0] inputs,
    output logic                       busy,
    output logic                       done,
    output logic                       class_o,
    output logic [ACC_W-1:0]           score_o
);
    localparam int NB   = (N_FEATURES + LANES - 1) / LANES;
    localparam int BT_W = NB > 1 ? $clog2(NB) : 1;
    localparam int PW   = W_W + IN_W + 1;
`ifdef SEQ_SVM_SAT_EN
    localparam int SW = ACC_W + PW + $clog2(LANES + 1) + 1;
    localparam logic signed [SW-1:0] SMAX = SW'({(ACC_W-1){1'b1}});
    localparam logic signed [SW-1:0] SMIN = ~SMAX;
`else
    localparam int SW = ACC_W;
`endif

    if (ACC_W < B_W + BIAS_SHIFT + 1) begin : g_acc_w_chk
        $error("seq_svm_mac: ACC_W too narrow to hold the shifted bias");
    end
    if (LANES < 1 || LANES > N_FEATURES) begin : g_lanes_chk
        $error("seq_svm_mac: LANES must be within 1..N_FEATURES");
    end

    typedef enum logic {IDLE, ACC} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, score_q, score_d;
    logic [BT_W-1:0]          beat_q, beat_d;
    logic                     busy_q, busy_d, done_q, done_d, class_q, class_d;
    logic signed [SW-1:0]     partial, sum;
    logic signed [ACC_W-1:0]  acc_upd;
    logic [ACC_W-1:0]         bias_ext;
    logic signed [W_W-1:0]    wk;
    logic signed [IN_W:0]     xk;
    int                       kk;

    assign bias_ext = {{(ACC_W-B_W){bias[B_W-1]}}, bias} << BIAS_SHIFT;

    // Sum this beat's lane products; lanes past the last feature add nothing.
    always_comb begin
        partial = '0;
        kk = 0;
        wk = '0;
        xk = '0;
        for (int j = 0; j < LANES; j++) begin
            kk = int'(beat_q) * LANES + j;
            wk = weights[(kk < N_FEATURES ? kk : 0) * W_W +: W_W];
            xk = {1'b0, inputs[(kk < N_FEATURES ? kk : 0) * IN_W +: IN_W]};
            if (kk < N_FEATURES) partial = partial + SW'(wk * xk);
        end
    end

    // Accumulator update: wrap by default, clamp to the ACC_W range when saturation is built in.
    always_comb begin
        sum = SW'(acc_q) + partial;
`ifdef SEQ_SVM_SAT_EN
        acc_upd = sum > SMAX ? SMAX[ACC_W-1:0] : sum < SMIN ? SMIN[ACC_W-1:0] : sum[ACC_W-1:0];
`else
        acc_upd = sum[ACC_W-1:0];
`endif
    end

    // Next-state: IDLE loads the scaled bias on start; ACC adds one beat per cycle and finishes on the last.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        score_d = score_q;
        class_d = class_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                acc_d   = bias_ext;
                beat_d  = '0;
                busy_d  = 1'b1;
                state_d = ACC;
            end
        end else begin
            acc_d  = acc_upd;
            beat_d = beat_q + 1'b1;
            if (beat_q == BT_W'(NB - 1)) begin
                score_d = acc_upd;
                class_d = acc_upd[ACC_W-1];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // State and result registers; reset aborts any evaluation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            beat_q  <= '0;
            score_q <= '0;
            class_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            score_q <= score_d;
            class_q <= class_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign class_o = class_q;
    assign score_o = score_q;
endmodule
